register_bank: RTL

Parametrised successor to the 2-port 4x8 register file. It adds a configurable width, depth and read-port count, a per-register scoreboard that tracks outstanding writes for hazard detection in ID, and a sequential clear sweep that zeroes the storage after reset or on request. It sits between ID (read and issue) and DM (writeback), and keeps write-to-read forwarding within the same cycle.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_clear_fsm.sv | 55 +++++
 rtl/register_bank.sv | 107 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register_bank slice.
package regfile_pkg;

  typedef enum logic {RF_CLEAR, RF_IDLE} rf_state_t;

  function automatic int unsigned rf_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep controller: walks every register address once after reset or
// on sig_clear, then holds IDLE (sig_ready=1).
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = 2
) (
  input  logic              sig_clk,
  input  logic              sig_rst_n,
  input  logic              sig_clear,
  output logic              sig_ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_state_t         state, state_next;
  logic [ADDR_W-1:0] counter, counter_next;

  always_ff @(posedge sig_clk or negedge sig_rst_n) begin
    if (!sig_rst_n) begin
      state   <= RF_CLEAR;
      counter <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  // Counter wraps to 0 naturally on the last address, so the exit needs no reload.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    unique case (state)
      RF_CLEAR: begin
        counter_next = counter + 1'b1;
        if (counter == '1) state_next = RF_IDLE;
      end
      RF_IDLE: begin
        if (sig_clear) begin
          state_next   = RF_CLEAR;
          counter_next = '0;
        end
      end
      default: begin
        state_next   = RF_CLEAR;
        counter_next = '0;
      end
    endcase
  end

  assign sig_ready = (state == RF_IDLE);
  assign clr_we    = (state == RF_CLEAR);
  assign clr_addr  = counter;

endmodule

// File: rtl/register_bank.sv
// Parametrised register file with pending-write scoreboard, same-cycle
// writeback forwarding and a clear sweep. Optional macro: REGFILE_ZERO_REG_EN.
module register_bank
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned RD_PORTS = 2
) (
  input  logic                       sig_clk,
  input  logic                       sig_rst_n,
  input  logic [RD_PORTS*ADDR_W-1:0] ID_addr_read,
  output logic [RD_PORTS*DATA_W-1:0] ID_data_read,
  output logic [RD_PORTS-1:0]        ID_pending_read,
  input  logic [ADDR_W-1:0]          ID_addr_issue,
  input  logic                       ID_sig_issue,
  input  logic [ADDR_W-1:0]          DM_addr_write,
  input  logic [DATA_W-1:0]          DM_data_write,
  input  logic                       DM_sig_write,
  input  logic                       sig_clear,
  output logic                       sig_ready
);

  localparam int unsigned DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] regfile [DEPTH];
  logic [DEPTH-1:0]  pending;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              dm_we;
  logic              issue_en;
  logic              st_we;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .sig_clk   (sig_clk),
    .sig_rst_n (sig_rst_n),
    .sig_clear (sig_clear),
    .sig_ready (sig_ready),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

`ifdef REGFILE_ZERO_REG_EN
  assign dm_we    = sig_ready & DM_sig_write & (|DM_addr_write);
  assign issue_en = sig_ready & ID_sig_issue & (|ID_addr_issue);
`else
  assign dm_we    = sig_ready & DM_sig_write;
  assign issue_en = sig_ready & ID_sig_issue;
`endif

  // Single storage write port shared by the sweep and DM writeback.
  assign st_we   = clr_we | dm_we;
  assign st_addr = clr_we ? clr_addr : DM_addr_write;
  assign st_data = clr_we ? '0 : DM_data_write;

  always_ff @(posedge sig_clk) begin
    if (st_we) regfile[st_addr] <= st_data;
  end

  // Issue is applied after writeback so it wins on an address collision.
  always_ff @(posedge sig_clk or negedge sig_rst_n) begin
    if (!sig_rst_n) begin
      pending <= '0;
    end else if (sig_ready) begin
      if (sig_clear) begin
        pending <= '0;
      end else begin
        if (dm_we)    pending[DM_addr_write] <= 1'b0;
        if (issue_en) pending[ID_addr_issue] <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rp;

    assign ra = ID_addr_read[p*ADDR_W +: ADDR_W];

    always_comb begin
      rd = '0;
      rp = 1'b0;
      if (!sig_ready) begin
        rd = '0;
`ifdef REGFILE_ZERO_REG_EN
      end else if (ra == '0) begin
        rd = '0;
`endif
      end else if (DM_sig_write && (DM_addr_write == ra)) begin
        rd = DM_data_write;
      end else begin
        rd = regfile[ra];
        rp = pending[ra];
      end
    end

    assign ID_data_read[p*DATA_W +: DATA_W] = rd;
    assign ID_pending_read[p]               = rp;
  end

endmodule
